pcmcia_io_spi: RTL and testbench

I/O-space register window for the CompactFlash/PCMCIA card that bridges host IOWR/IORD cycles to a buffered SPI master. It synchronises the asynchronous host strobes into the clk_26 domain, holds off the host with WAIT until read data is latched, and feeds the SPI engine through TX/RX FIFOs. It sits beside the attribute-memory ROM in the card top and owns the SS/SCLK/MOSI/MISO/INT pins.

---
 rtl/pcmcia_io_spi_if.sv | 23 ++
 rtl/pcmcia_io_spi.sv | 203 ++++++++++++++++++++
 tb/tb_pcmcia_io_spi.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcmcia_io_spi_if.sv
// rtl/pcmcia_io_spi_if.sv - host I/O bus bundle between the PCMCIA host and the SPI register window
interface pcmcia_io_spi_if;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        DDIR_IO;
  logic        IOWR;
  logic        IORD;
  logic        CE1;
  logic        REG;
  logic        INPACK;
  logic        WAIT;

  modport master (
    output A, D_in, IOWR, IORD, CE1, REG,
    input  D_out, DDIR_IO, INPACK, WAIT
  );

  modport slave (
    input  A, D_in, IOWR, IORD, CE1, REG,
    output D_out, DDIR_IO, INPACK, WAIT
  );
endinterface

// File: rtl/pcmcia_io_spi.sv
// rtl/pcmcia_io_spi.sv - PCMCIA I/O register window bridging host IOWR/IORD cycles to a FIFO-buffered SPI master
// Optional SPI_AUTO_CS_EN: selected SS also asserts automatically while a byte is in flight.
module pcmcia_io_spi #(
  parameter logic [11:0] BASE       = 12'h001,
  parameter int          FIFO_DEPTH = 8,
  parameter int          N_CS       = 1,
  parameter logic [7:0]  DIV_RESET  = 8'd12
) (
  input  logic            clk_26,
  input  logic            RESET_N,
  pcmcia_io_spi_if.slave  bus,
  output logic [N_CS-1:0] SS,
  output logic            SCLK,
  output logic            MOSI,
  input  logic            MISO,
  output logic            INT
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t      state;
  logic [2:0]  iowr_q, iord_q;
  logic        rd_valid;
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [AW:0] tx_cnt, rx_cnt;
  logic        tx_ovf, rx_ovf;
  logic [2:0]  cs_idx;
  logic        cs_assert, rx_ie;
  logic [7:0]  div_reg, div_act, hp_cnt;
  logic [3:0]  hp;
  logic [7:0]  tx_sh, rx_sh;
  logic [7:0]  rd_mux, status_byte;
  logic        sel, wr_act, rd_act, busy, cs_en;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic        wr_data, wr_status, wr_ctrl, wr_div, rd_data;
  logic        unused_addr;

  assign unused_addr = ^bus.A[3:2];

  assign sel         = ~bus.CE1 & ~bus.REG & (bus.A[15:4] == BASE);
  assign bus.INPACK  = ~(sel & ~bus.IORD);
  assign bus.DDIR_IO = sel & ~bus.IORD;
  assign bus.WAIT    = ~(sel & ~bus.IORD & ~rd_valid);

  // Action point: falling edge of the synchronised strobe, seen once per strobe.
  assign wr_act = iowr_q[2] & ~iowr_q[1] & sel;
  assign rd_act = iord_q[2] & ~iord_q[1] & sel;

  assign wr_data   = wr_act & (bus.A[1:0] == 2'd0);
  assign wr_status = wr_act & (bus.A[1:0] == 2'd1);
  assign wr_ctrl   = wr_act & (bus.A[1:0] == 2'd2);
  assign wr_div    = wr_act & (bus.A[1:0] == 2'd3);
  assign rd_data   = rd_act & (bus.A[1:0] == 2'd0);

  assign tx_full  = (tx_cnt == DEPTH_C);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == DEPTH_C);
  assign rx_empty = (rx_cnt == '0);
  assign busy     = (state != S_IDLE);

  assign tx_push     = wr_data & ~tx_full;
  assign tx_pop      = (state == S_IDLE) & ~tx_empty;
  assign rx_push_req = (state == S_DONE);
  assign rx_push     = rx_push_req & ~rx_full;
  assign rx_pop      = rd_data & ~rx_empty;

  assign status_byte = {1'b0, tx_ovf, rx_ovf, busy, rx_empty, rx_full, tx_empty, tx_full};

`ifdef SPI_AUTO_CS_EN
  assign cs_en = cs_assert | busy;
`else
  assign cs_en = cs_assert;
`endif

  always_comb begin
    for (int i = 0; i < N_CS; i++) begin
      SS[i] = ~(cs_en & (cs_idx == 3'(i)));
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.A[1:0])
      2'd0: rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rd];
      2'd1: rd_mux = status_byte;
      2'd2: rd_mux = {2'b00, rx_ie, 1'b0, cs_assert, cs_idx};
      2'd3: rd_mux = div_reg;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_26) begin
    if (tx_push) tx_mem[tx_wr] <= bus.D_in;
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end

  always_ff @(posedge clk_26 or negedge RESET_N) begin
    if (!RESET_N) begin
      iowr_q    <= 3'b111;
      iord_q    <= 3'b111;
      rd_valid  <= 1'b0;
      bus.D_out <= 8'h00;
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      cs_idx    <= 3'd0;
      cs_assert <= 1'b0;
      rx_ie     <= 1'b0;
      div_reg   <= DIV_RESET;
      div_act   <= DIV_RESET;
      INT       <= 1'b1;
      state     <= S_IDLE;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      hp        <= 4'd0;
      hp_cnt    <= 8'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
    end else begin
      iowr_q <= {iowr_q[1:0], bus.IOWR};
      iord_q <= {iord_q[1:0], bus.IORD};

      if (rd_act) begin
        bus.D_out <= rd_mux;
        rd_valid  <= 1'b1;
      end else if (iord_q[1]) begin
        rd_valid <= 1'b0;
      end

      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);

      // A new overflow in the same cycle as a clear wins.
      if (wr_status && bus.D_in[5]) rx_ovf <= 1'b0;
      if (rx_push_req && rx_full)   rx_ovf <= 1'b1;
      if (wr_status && bus.D_in[6]) tx_ovf <= 1'b0;
      if (wr_data && tx_full)       tx_ovf <= 1'b1;

      if (wr_ctrl) begin
        cs_idx    <= bus.D_in[2:0];
        cs_assert <= bus.D_in[3];
        rx_ie     <= bus.D_in[5];
      end
      if (wr_div) div_reg <= bus.D_in;

      INT <= ~(rx_ie & ~rx_empty);

      case (state)
        S_IDLE: begin
          SCLK <= 1'b0;
          if (!tx_empty) begin
            tx_sh   <= tx_mem[tx_rd];
            MOSI    <= tx_mem[tx_rd][7];
            div_act <= div_reg;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          hp     <= 4'd0;
          hp_cnt <= 8'd0;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (hp_cnt == div_act) begin
            hp_cnt <= 8'd0;
            hp     <= hp + 4'd1;
            if (!hp[0]) begin
              SCLK  <= 1'b1;
              rx_sh <= {rx_sh[6:0], MISO};
            end else begin
              SCLK  <= 1'b0;
              tx_sh <= {tx_sh[6:0], 1'b0};
              MOSI  <= tx_sh[6];
              if (hp == 4'd15) state <= S_DONE;
            end
          end else begin
            hp_cnt <= hp_cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcmcia_io_spi.sv
// tb/tb_pcmcia_io_spi.sv - self-checking bench for pcmcia_io_spi
`timescale 1ns/1ps
module tb_pcmcia_io_spi;
  localparam logic [11:0] BASE = 12'h001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ss;
  logic       sclk, mosi, miso, int_n;
  logic       loop_en, miso_val, mon_en;
  int         errors = 0;
  int         checks = 0;

  always #19 clk = ~clk;
  assign miso = loop_en ? mosi : miso_val;

  pcmcia_io_spi_if bus_if();

  pcmcia_io_spi #(.BASE(BASE), .FIFO_DEPTH(8), .N_CS(4), .DIV_RESET(8'd12)) dut (
    .clk_26 (clk),
    .RESET_N(rst_n),
    .bus    (bus_if.slave),
    .SS     (ss),
    .SCLK   (sclk),
    .MOSI   (mosi),
    .MISO   (miso),
    .INT    (int_n)
  );

  int   cyc = 0;
  int   rise_t[$];
  bit   rise_b[$];
  logic sclk_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en && sclk && !sclk_d) begin
      rise_t.push_back(cyc);
      rise_b.push_back(mosi);
    end
    sclk_d = sclk;
  end

  initial begin
    #(38 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [7:0] rd;
    logic [3:0] ss;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [1:0] a, input logic [7:0] d);
    bus_if.A = {BASE, 2'b00, a};
    bus_if.D_in = d;
    bus_if.CE1 = 1'b0;
    bus_if.REG = 1'b0;
    bus_if.IOWR = 1'b0;
    tick(5);
    bus_if.IOWR = 1'b1;
    bus_if.CE1 = 1'b1;
    bus_if.REG = 1'b1;
    tick(3);
  endtask

  task automatic io_read(input logic [1:0] a, output logic [7:0] d, output int wc,
                         output logic w0, output logic ip0, output logic dd0,
                         output logic irq_rel, output logic irq_nxt);
    bus_if.A = {BASE, 2'b00, a};
    bus_if.CE1 = 1'b0;
    bus_if.REG = 1'b0;
    bus_if.IORD = 1'b0;
    #1;
    w0 = bus_if.WAIT;
    ip0 = bus_if.INPACK;
    dd0 = bus_if.DDIR_IO;
    wc = 0;
    while (bus_if.WAIT == 1'b0 && wc < 10) begin
      tick(1);
      wc++;
    end
    d = bus_if.D_out;
    irq_rel = int_n;
    tick(1);
    irq_nxt = int_n;
    bus_if.IORD = 1'b1;
    bus_if.CE1 = 1'b1;
    bus_if.REG = 1'b1;
    tick(4);
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    int wc;
    logic w0, ip0, dd0, i0, i1;
    io_read(a, d, wc, w0, ip0, dd0, i0, i1);
    check(name, d, exp);
  endtask

  function automatic logic [3:0] model_ss(input logic [7:0] ctrl, input bit in_flight);
    bit en;
    int idx;
    en = ctrl[3];
`ifdef SPI_AUTO_CS_EN
    en = en | in_flight;
`endif
    idx = int'(ctrl[2:0]);
    if (en && idx < 4) return ~(4'b0001 << idx);
    return 4'hF;
  endfunction

  initial begin
    vec_t       vt[7];
    logic [7:0] d, b0, b1, v;
    logic [7:0] q[$];
    int         wc, n, dv;
    logic       w0, ip0, dd0, i0, i1;

    vt[0] = '{2'd2, 8'hFF, 2'd2, 8'h2F, 4'hF};
    vt[1] = '{2'd2, 8'h15, 2'd2, 8'h05, 4'hF};
    vt[2] = '{2'd2, 8'h28, 2'd2, 8'h28, 4'hE};
    vt[3] = '{2'd3, 8'h00, 2'd3, 8'h00, 4'hE};
    vt[4] = '{2'd3, 8'hFE, 2'd3, 8'hFE, 4'hE};
    vt[5] = '{2'd1, 8'h60, 2'd1, 8'h0A, 4'hE};
    vt[6] = '{2'd2, 8'h00, 2'd2, 8'h00, 4'hF};

    bus_if.A = 16'h0; bus_if.D_in = 8'h0;
    bus_if.CE1 = 1'b1; bus_if.REG = 1'b1; bus_if.IOWR = 1'b1; bus_if.IORD = 1'b1;
    loop_en = 1'b1; miso_val = 1'b0; mon_en = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    check("rst_ss", ss, 4'hF);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_int", int_n, 1'b1);
    check("rst_dout", bus_if.D_out, 8'h00);
    check("rst_wait", bus_if.WAIT, 1'b1);
    check("rst_inpack", bus_if.INPACK, 1'b1);
    chk_rd("rst_status", 2'd1, 8'h0A);
    chk_rd("rst_div", 2'd3, 8'h0C);
    chk_rd("rst_ctrl", 2'd2, 8'h00);
    chk_rd("rd_empty_data", 2'd0, 8'h00);

    for (int i = 0; i < 7; i++) begin
      io_write(vt[i].wa, vt[i].wd);
      chk_rd($sformatf("vec%0d_rd", i), vt[i].ra, vt[i].rd);
      check($sformatf("vec%0d_ss", i), ss, vt[i].ss);
    end

    // Two back-to-back loopback bytes at the fastest divider.
    io_write(2'd3, 8'h00);
    io_write(2'd2, 8'h08);
    check("cs0_ss", ss, 4'hE);
    rise_t.delete();
    rise_b.delete();
    mon_en = 1'b1;
    io_write(2'd0, 8'hA5);
    io_write(2'd0, 8'h3C);
    tick(60);
    mon_en = 1'b0;
    check("rise_count", rise_t.size(), 16);
    if (rise_t.size() >= 16) begin
      b0 = 8'h00;
      b1 = 8'h00;
      for (int i = 0; i < 8; i++) begin
        b0 = {b0[6:0], rise_b[i]};
        b1 = {b1[6:0], rise_b[i+8]};
      end
      check("mosi_byte0", b0, 8'hA5);
      check("mosi_byte1", b1, 8'h3C);
      check("rise_span_in_byte", rise_t[7] - rise_t[0], 14);
      check("byte_period", rise_t[8] - rise_t[0], 19);
    end
    chk_rd("loop_rx0", 2'd0, 8'hA5);
    chk_rd("loop_rx1", 2'd0, 8'h3C);
    chk_rd("loop_status", 2'd1, 8'h0A);

    // Interrupt and host wait handshake on a DATA read.
    io_write(2'd2, 8'h20);
    io_write(2'd0, 8'h5A);
    tick(40);
    check("int_pending", int_n, 1'b0);
    io_read(2'd0, d, wc, w0, ip0, dd0, i0, i1);
    check("irq_rd_data", d, 8'h5A);
    check("irq_wait_asserted", w0, 1'b0);
    check("irq_inpack", ip0, 1'b0);
    check("irq_ddir", dd0, 1'b1);
    check("wait_le4", (wc >= 1 && wc <= 4), 1'b1);
    check("int_at_release", i0, 1'b0);
    check("int_after_pop", i1, 1'b1);

    bus_if.A = {12'h002, 4'h0};
    bus_if.CE1 = 1'b0; bus_if.REG = 1'b0; bus_if.IORD = 1'b0;
    #1;
    check("nomatch_wait", bus_if.WAIT, 1'b1);
    check("nomatch_ddir", bus_if.DDIR_IO, 1'b0);
    check("nomatch_inpack", bus_if.INPACK, 1'b1);
    bus_if.CE1 = 1'b1; bus_if.REG = 1'b1; bus_if.IORD = 1'b1;
    tick(4);

    // RX overflow with MISO held high.
    io_write(2'd2, 8'h00);
    loop_en = 1'b0;
    miso_val = 1'b1;
    for (int i = 0; i < 9; i++) io_write(2'd0, 8'($urandom));
    tick(250);
    chk_rd("rxovf_status", 2'd1, 8'h26);
    for (int i = 0; i < 8; i++) chk_rd($sformatf("rxovf_byte%0d", i), 2'd0, 8'hFF);
    chk_rd("rxovf_drained", 2'd1, 8'h2A);
    io_write(2'd1, 8'h20);
    chk_rd("rxovf_cleared", 2'd1, 8'h0A);
    loop_en = 1'b1;

    // Chip-select behaviour during a transfer.
    io_write(2'd3, 8'h03);
    io_write(2'd2, 8'h02);
    check("cs_idle", ss, 4'hF);
    io_write(2'd0, 8'h77);
    tick(10);
    check("cs_busy", ss, model_ss(8'h02, 1'b1));
    io_write(2'd2, 8'h0A);
    check("cs_assert_busy", ss, 4'b1011);
    io_write(2'd2, 8'h0F);
    check("cs_out_of_range", ss, 4'hF);
    io_write(2'd2, 8'h02);
    tick(100);
    check("cs_idle_after", ss, 4'hF);
    chk_rd("cs_rx", 2'd0, 8'h77);

    // Randomised traffic against a queue model.
    for (int it = 0; it < 5; it++) begin
      dv = $urandom_range(0, 3);
      n = $urandom_range(1, 8);
      v = 8'($urandom);
      io_write(2'd2, v);
      chk_rd($sformatf("rnd%0d_ctrl", it), 2'd2, {2'b00, v[5], 1'b0, v[3], v[2:0]});
      check($sformatf("rnd%0d_ss", it), ss, model_ss(v, 1'b0));
      io_write(2'd3, 8'(dv));
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        q.push_back(d);
        io_write(2'd0, d);
      end
      tick(n * (16 * (dv + 1) + 3) + 20);
      for (int k = 0; k < n; k++) begin
        b0 = q.pop_front();
        chk_rd($sformatf("rnd%0d_rx%0d", it, k), 2'd0, b0);
      end
      chk_rd($sformatf("rnd%0d_status", it), 2'd1, 8'h0A);
    end

    // TX overflow at the slowest divider, then reset in the middle of SHIFT.
    io_write(2'd2, 8'h08);
    io_write(2'd3, 8'hFF);
    for (int i = 0; i < 9; i++) io_write(2'd0, 8'(i + 1));
    chk_rd("txfull_status", 2'd1, 8'h19);
    io_write(2'd0, 8'hEE);
    chk_rd("txovf_status", 2'd1, 8'h59);
    io_write(2'd1, 8'h40);
    chk_rd("txovf_cleared", 2'd1, 8'h19);
    tick(300);
    check("pre_reset_ss", ss, 4'hE);
    rst_n = 1'b0;
    #1;
    check("reset_ss", ss, 4'hF);
    check("reset_sclk", sclk, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("reset_int", int_n, 1'b1);
    chk_rd("reset_status", 2'd1, 8'h0A);
    chk_rd("reset_div", 2'd3, 8'h0C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
